scs8hd_bufbank_seq: RTL and testbench

Staggered enable sequencer for a bank of high-drive inverting buffers (bufinv_8-class cells) driving a shared heavy net. It turns banks on one at a time, LSB first, and off one at a time, MSB first, with a programmable gap between steps. This bounds the di/dt and inrush on vpwr/vgnd. It sits in the always-on control domain beside the buffer bank, and its bank_en outputs gate each bank's input.

---
 rtl/scs8hd_bufbank_seq.sv | 116 +++++++++++
 tb/tb_scs8hd_bufbank_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_bufbank_seq.sv
// Staggered enable sequencer for a bank of high-drive inverting buffers.
// Banks turn on LSB first and off MSB first, one per step, with a programmable gap between steps.
module scs8hd_bufbank_seq #(
  parameter int unsigned NBANK = 8,
  parameter int unsigned GAPW  = 8,
  localparam int unsigned LW   = $clog2(NBANK + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              on,
  input  logic              freeze,
  input  logic [GAPW-1:0]   gap,
  output logic [NBANK-1:0]  bank_en,
  output logic [LW-1:0]     level,
  output logic              busy,
  output logic              all_on,
  output logic              all_off
);

  typedef enum logic [1:0] {
    S_OFF,
    S_RAMP_UP,
    S_ON,
    S_RAMP_DOWN
  } state_t;

  localparam logic [LW-1:0] LVL_FULL = LW'(NBANK);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  state_t            state, state_nx;
  logic [GAPW-1:0]   timer, timer_nx;
  logic [LW-1:0]     level_nx;
  logic [NBANK-1:0]  bank_nx;

  // Shifting the thermometer keeps bank_en contiguous from bit 0 and flips exactly one bit per step.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    level_nx = level;
    bank_nx  = bank_en;
    if (!freeze) begin
      unique case (state)
        S_OFF: begin
          if (on) begin
            level_nx = level + LVL_ONE;
            bank_nx  = {bank_en[NBANK-2:0], 1'b1};
            timer_nx = gap;
            state_nx = (level_nx == LVL_FULL) ? S_ON : S_RAMP_UP;
          end
        end
        S_RAMP_UP: begin
          if (!on) begin
            state_nx = S_RAMP_DOWN;
            timer_nx = gap;
          end else if (timer == '0) begin
            level_nx = level + LVL_ONE;
            bank_nx  = {bank_en[NBANK-2:0], 1'b1};
            timer_nx = gap;
            if (level_nx == LVL_FULL) state_nx = S_ON;
          end else begin
            timer_nx = timer - GAPW'(1);
          end
        end
        S_ON: begin
          if (!on) begin
            level_nx = level - LVL_ONE;
            bank_nx  = {1'b0, bank_en[NBANK-1:1]};
            timer_nx = gap;
            state_nx = (level_nx == '0) ? S_OFF : S_RAMP_DOWN;
          end
        end
        S_RAMP_DOWN: begin
          if (on) begin
            state_nx = S_RAMP_UP;
            timer_nx = gap;
          end else if (timer == '0) begin
            level_nx = level - LVL_ONE;
            bank_nx  = {1'b0, bank_en[NBANK-1:1]};
            timer_nx = gap;
            if (level_nx == '0) state_nx = S_OFF;
          end else begin
            timer_nx = timer - GAPW'(1);
          end
        end
        default: begin
          state_nx = S_OFF;
          level_nx = '0;
          bank_nx  = '0;
          timer_nx = '0;
        end
      endcase
    end
  end

  // Status flags are computed from next-state values so they move on the same edge as the level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_OFF;
      timer   <= '0;
      level   <= '0;
      bank_en <= '0;
      busy    <= 1'b0;
      all_on  <= 1'b0;
      all_off <= 1'b1;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      level   <= level_nx;
      bank_en <= bank_nx;
      busy    <= (state_nx == S_RAMP_UP) || (state_nx == S_RAMP_DOWN);
      all_on  <= (level_nx == LVL_FULL);
      all_off <= (level_nx == '0);
    end
  end

endmodule

// File: tb/tb_scs8hd_bufbank_seq.sv
// Bench for scs8hd_bufbank_seq: directed scenarios plus random on/freeze/gap traffic,
// checked every edge against a model that schedules steps by absolute edge number.
module tb_scs8hd_bufbank_seq;
  localparam int unsigned NBANK = 8;
  localparam int unsigned GAPW  = 8;
  localparam int unsigned LW    = $clog2(NBANK + 1);

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              on = 1'b0;
  logic              freeze = 1'b0;
  logic [GAPW-1:0]   gap = '0;
  logic [NBANK-1:0]  bank_en;
  logic [LW-1:0]     level;
  logic              busy, all_on, all_off;

  scs8hd_bufbank_seq #(.NBANK(NBANK), .GAPW(GAPW)) dut (
    .CLK(CLK), .RESET(RESET), .on(on), .freeze(freeze), .gap(gap),
    .bank_en(bank_en), .level(level), .busy(busy), .all_on(all_on), .all_off(all_off)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;
  // Model: level count, whether a ramp is in progress, its direction, and the edge of the next step.
  int m_lvl = 0;
  int m_next = 0;
  bit m_ramp = 1'b0;
  bit m_up = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    logic [31:0] exp_bank;
    exp_bank = (32'd1 << m_lvl) - 32'd1;
    chk("bank_en", 32'(bank_en), exp_bank);
    chk("level",   32'(level), 32'(m_lvl));
    chk("busy",    32'(busy), 32'(m_ramp));
    chk("all_on",  32'(all_on), 32'(m_lvl == NBANK));
    chk("all_off", 32'(all_off), 32'(m_lvl == 0));
  endtask

  task automatic model_reset();
    m_lvl = 0;
    m_ramp = 1'b0;
    m_up = 1'b0;
  endtask

  task automatic model_edge();
    if (RESET) begin
      model_reset();
    end else if (freeze) begin
      if (m_ramp) m_next++;
    end else if (!m_ramp) begin
      if (on && m_lvl == 0) begin
        m_lvl = 1;
        m_up = 1'b1;
        m_ramp = (m_lvl < NBANK);
        m_next = edge_n + int'(gap) + 1;
      end else if (!on && m_lvl == NBANK) begin
        m_lvl = m_lvl - 1;
        m_up = 1'b0;
        m_ramp = (m_lvl > 0);
        m_next = edge_n + int'(gap) + 1;
      end
    end else if (on != m_up) begin
      m_up = on;
      m_next = edge_n + int'(gap) + 1;
    end else if (edge_n == m_next) begin
      m_lvl = m_up ? m_lvl + 1 : m_lvl - 1;
      m_next = edge_n + int'(gap) + 1;
      if (m_lvl == 0 || m_lvl == NBANK) m_ramp = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    edge_n++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_level(input int target, input int budget);
    int k;
    k = 0;
    while (int'(level) != target && k < budget) begin
      step();
      k++;
    end
    chk("wait_level", 32'(level), 32'(target));
  endtask

  initial begin
    // Asynchronous reset from power-up
    #1 RESET = 1'b1;
    #1 model_reset();
    check_all();
    run(2);
    RESET = 1'b0;
    run(2);

    // Slow ramp up, gap=3: one bank every 4 edges, full after 29 edges
    gap = 8'd3;
    on = 1'b1;
    step();
    chk("first_bank", 32'(bank_en), 32'h01);
    run(27);
    chk("pre_full", 32'(bank_en), 32'h7F);
    step();
    chk("full_bank", 32'(bank_en), 32'hFF);
    chk("full_busy", 32'(busy), 32'd0);
    run(3);

    // Fast ramp down, gap=0: one bank per edge
    gap = 8'd0;
    on = 1'b0;
    run(7);
    chk("down_last1", 32'(bank_en), 32'h01);
    step();
    chk("down_off", 32'(all_off), 32'd1);
    run(2);

    // Direction changes mid-ramp with gap=2
    gap = 8'd2;
    on = 1'b1;
    run_until_level(5, 40);
    on = 1'b0;
    run(3);
    chk("hold_at5", 32'(level), 32'd5);
    run_until_level(2, 40);
    on = 1'b1;
    run(3);
    chk("hold_at2", 32'(level), 32'd2);
    run(30);

    // Freeze mid ramp-down with on toggling underneath
    gap = 8'd3;
    on = 1'b0;
    run(5);
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      on = ~on;
      step();
    end
    freeze = 1'b0;
    on = 1'b0;
    run(40);

    // Gap change 5 -> 1 while the timer is mid-interval
    gap = 8'd5;
    on = 1'b1;
    run(3);
    gap = 8'd1;
    run(20);

    // Asynchronous reset in the middle of a ramp
    on = 1'b0;
    gap = 8'd0;
    run_until_level(0, 20);
    gap = 8'd1;
    on = 1'b1;
    run_until_level(6, 30);
    #3 RESET = 1'b1;
    #1 model_reset();
    check_all();
    step();
    RESET = 1'b0;
    run(20);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) on = ~on;
      freeze = ($urandom_range(0, 9) == 0);
      gap = GAPW'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
